// File: rtl/fa_result_checker.sv
// Response monitor for full-adder / ripple-adder DUTs.
// Compares each accepted vector with a golden sum and keeps session statistics.
module fa_result_checker #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iEnd,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  input  logic [WIDTH-1:0] iS,
  input  logic             iCo,
  output logic             oMismatch,
  output logic [WIDTH-1:0] oExpS,
  output logic             oExpC,
  output logic [CNT_W-1:0] oVecCnt,
  output logic [CNT_W-1:0] oErrCnt,
  output logic [CNT_W-1:0] oFirstErr,
  output logic             oDone,
  output logic             oPass
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state_q, state_d;
  logic clr, acc, retire, mis;

  logic             vld_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             c_q, co_q;

  logic [WIDTH:0]   gold;
  logic [WIDTH:0]   exp_q, exp_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (iStart) begin
          clr = 1'b1;
        end else begin
          acc = iValid;
          if (iEnd) state_d = DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (iStart) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A restart discards whatever is still sitting in the pipe.
  assign retire = vld_q && !clr;
  assign gold   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_q};
  assign mis    = ({co_q, s_q} !== gold);

  always_comb begin
    exp_d = exp_q;
    mis_d = 1'b0;
    vec_d = vec_q;
    err_d = err_q;
    fe_d  = fe_q;
    if (clr) begin
      vec_d = '0;
      err_d = '0;
      fe_d  = '1;
    end else if (retire) begin
      exp_d = gold;
      mis_d = mis;
      if (vec_q != CNT_MAX) vec_d = vec_q + 1'b1;
      if (mis) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (err_q == '0) fe_d = vec_q;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      fe_q    <= '1;
    end else begin
      state_q <= state_d;
      vld_q   <= acc;
      if (acc) begin
        a_q  <= iA;
        b_q  <= iB;
        c_q  <= iC;
        s_q  <= iS;
        co_q <= iCo;
      end
      exp_q <= exp_d;
      mis_q <= mis_d;
      vec_q <= vec_d;
      err_q <= err_d;
      fe_q  <= fe_d;
    end
  end

  assign oReady    = (state_q == RUN);
  assign oDone     = (state_q == DONE);
  assign oPass     = oDone && (err_q == '0) && (vec_q != '0);
  assign oMismatch = mis_q;
  assign oExpS     = exp_q[WIDTH-1:0];
  assign oExpC     = exp_q[WIDTH];
  assign oVecCnt   = vec_q;
  assign oErrCnt   = err_q;
  assign oFirstErr = fe_q;

endmodule

// File: tb/tb_fa_result_checker.sv
// Directed bench for fa_result_checker (WIDTH=1, CNT_W=8).
// Expected values are hand-computed per session.
module tb_fa_result_checker;

  logic       clk = 1'b0;
  logic       iRst, iStart, iEnd, iValid;
  logic       oReady;
  logic [0:0] iA, iB, iS, oExpS;
  logic       iC, iCo;
  logic       oMismatch, oExpC, oDone, oPass;
  logic [7:0] oVecCnt, oErrCnt, oFirstErr;

  int checks = 0;
  int fails  = 0;
  int mis_n  = 0;

  always #5 clk = ~clk;

  fa_result_checker #(.WIDTH(1), .CNT_W(8)) dut (
    .iClk(clk), .iRst(iRst), .iStart(iStart), .iEnd(iEnd),
    .iValid(iValid), .oReady(oReady), .iA(iA), .iB(iB), .iC(iC),
    .iS(iS), .iCo(iCo), .oMismatch(oMismatch), .oExpS(oExpS),
    .oExpC(oExpC), .oVecCnt(oVecCnt), .oErrCnt(oErrCnt),
    .oFirstErr(oFirstErr), .oDone(oDone), .oPass(oPass)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (oMismatch === 1'b1) mis_n++;
  endtask

  task automatic set_vec(input logic a, input logic b, input logic c,
                         input logic stuck);
    logic [1:0] t;
    t      = {1'b0, a} + {1'b0, b} + {1'b0, c};
    iA     = a;
    iB     = b;
    iC     = c;
    iS     = t[0];
    iCo    = stuck ? 1'b0 : t[1];
    iValid = 1'b1;
  endtask

  task automatic start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    mis_n  = 0;
  endtask

  task automatic finish_sess();
    iValid = 1'b0;
    iEnd   = 1'b1;
    tick();
    iEnd = 1'b0;
    tick();
  endtask

  task automatic run5(input logic stuck);
    set_vec(0, 1, 0, stuck); tick();
    set_vec(0, 0, 0, stuck); tick();
    set_vec(1, 1, 0, stuck); tick();
    set_vec(1, 0, 1, stuck); tick();
    set_vec(1, 1, 1, stuck); tick();
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iEnd = 1'b0; iValid = 1'b0;
    iA = '0; iB = '0; iC = 1'b0; iS = '0; iCo = 1'b0;
    tick(); tick();
    iRst = 1'b0;
    chk("rst_ready", oReady, 0);
    chk("rst_mis", oMismatch, 0);
    chk("rst_exps", oExpS, 0);
    chk("rst_expc", oExpC, 0);
    chk("rst_vec", oVecCnt, 0);
    chk("rst_err", oErrCnt, 0);
    chk("rst_first", oFirstErr, 8'hff);
    chk("rst_done", oDone, 0);
    chk("rst_pass", oPass, 0);

    // 1: good DUT
    start();
    chk("t1_ready", oReady, 1);
    run5(1'b0);
    iValid = 1'b0;
    iEnd   = 1'b1;
    tick();
    iEnd = 1'b0;
    chk("t1_drain_done", oDone, 0);
    chk("t1_drain_ready", oReady, 0);
    tick();
    chk("t1_done", oDone, 1);
    chk("t1_vec", oVecCnt, 5);
    chk("t1_err", oErrCnt, 0);
    chk("t1_pass", oPass, 1);
    chk("t1_mis", mis_n, 0);
    chk("t1_exps", oExpS, 1);
    chk("t1_expc", oExpC, 1);

    // 2: stuck-at-0 carry
    start();
    chk("t2_notdone", oDone, 0);
    run5(1'b1);
    finish_sess();
    chk("t2_done", oDone, 1);
    chk("t2_vec", oVecCnt, 5);
    chk("t2_err", oErrCnt, 3);
    chk("t2_first", oFirstErr, 2);
    chk("t2_pass", oPass, 0);
    chk("t2_mis", mis_n, 3);

    // 3: valid and end on the same edge
    start();
    set_vec(1, 1, 1, 1'b0);
    iEnd = 1'b1;
    tick();
    iValid = 1'b0;
    iEnd   = 1'b0;
    tick();
    chk("t3_done", oDone, 1);
    chk("t3_vec", oVecCnt, 1);
    chk("t3_pass", oPass, 1);

    // 4: saturation
    start();
    for (int i = 0; i < 300; i++) begin
      set_vec(i[0], i[1], i[2], 1'b0);
      tick();
    end
    finish_sess();
    chk("t4_vec", oVecCnt, 255);
    chk("t4_err", oErrCnt, 0);
    chk("t4_pass", oPass, 1);

    // 5: reset mid-run
    start();
    set_vec(1, 1, 0, 1'b1); tick();
    set_vec(1, 0, 0, 1'b0); tick();
    set_vec(1, 1, 1, 1'b1); tick();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    chk("t5_vec", oVecCnt, 0);
    chk("t5_err", oErrCnt, 0);
    chk("t5_first", oFirstErr, 8'hff);
    chk("t5_mis", oMismatch, 0);
    chk("t5_exps", oExpS, 0);
    chk("t5_expc", oExpC, 0);
    chk("t5_ready", oReady, 0);
    tick(); tick();
    chk("t5_idle_vec", oVecCnt, 0);
    chk("t5_idle_mis", oMismatch, 0);
    iValid = 1'b0;

    // start and end together: start wins
    start();
    set_vec(0, 1, 1, 1'b1); tick();
    iValid = 1'b0;
    iStart = 1'b1;
    iEnd   = 1'b1;
    tick();
    iStart = 1'b0;
    iEnd   = 1'b0;
    chk("se_ready", oReady, 1);
    chk("se_vec", oVecCnt, 0);
    chk("se_err", oErrCnt, 0);

    // 6: end with no vectors
    finish_sess();
    chk("t6_done", oDone, 1);
    chk("t6_vec", oVecCnt, 0);
    chk("t6_pass", oPass, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
